pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
Supervises the Gowin rPLL from its reference-clock side.
- Drives the PLL's active-high RESET and watches its asynchronous LOCK output.
- Retries the PLL on lock timeout.
- Holds the core reset until lock is stable, then releases it.
- Re-sequences on lock loss.
- Runs on the 27 MHz crystal clock, not the PLL output, so it keeps working while the PLL is unlocked.

Parameters:
- PLL_RST_CYCLES, 27: cycles pll_reset_o is held high per attempt (1 us at 27 MHz).
- LOCK_TIMEOUT, 2700000: cycles to wait for lock per attempt (100 ms).
- STABLE_CYCLES, 270000: cycles lock must stay continuously high before it is accepted (10 ms).
- RST_HOLD_CYCLES, 16: cycles the core stays in reset after lock is accepted.
- MAX_RETRIES, 7: retries after the first attempt before giving up; must be at most 15.
- CNT_W, 22: counter width; must hold the largest cycle parameter minus 1.

Ports:
- clkin, input, 1: 27 MHz reference clock; the only clock.
- rst_n, input, 1: asynchronous, active-low reset.
- lock_i, input, 1: PLL LOCK; asynchronous to clkin.
- pll_reset_o, output, 1: to the rPLL RESET input; active high.
- sys_reset_n_o, output, 1: core reset, active low. Asserts asynchronously on rst_n; deasserts synchronously to clkin. Consumers resynchronise it into the clkout domain.
- locked_o, output, 1: high in S_HOLD and S_RUN.
- fail_o, output, 1: high in S_FAIL (sticky).
- retry_cnt_o, output, 4: retries used in the current sequence.
- relock_evt_o, output, 1: one-cycle pulse on lock loss while in S_RUN.

Behaviour:
- Reset values (rst_n low): state S_PLLRST, pll_reset_o=1, sys_reset_n_o=0, locked_o=0, fail_o=0, retry_cnt_o=0, relock_evt_o=0, counter 0.
- Synchronisation: lock_i passes through a 2-flop synchronizer to give lock_s (2 cycles of latency). Only lock_s is used by the FSM.
- Counter rule: the cycle counter clears on every state transition. A phase of N cycles ends when the counter equals N-1, with the transition on that edge.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- S_PLLRST:
  - Outputs: pll_reset_o=1, sys_reset_n_o=0.
  - After PLL_RST_CYCLES cycles, go to S_WAIT.
- S_WAIT:
  - Outputs: pll_reset_o=0.
  - lock_s=1: go to S_STABLE.
  - Timeout (LOCK_TIMEOUT cycles) with retry_cnt==MAX_RETRIES: go to S_FAIL.
  - Timeout otherwise: retry_cnt+1, go to S_PLLRST.
- S_STABLE:
  - lock_s=0: go to S_WAIT with the counter restarted; glitches do not consume a retry.
  - After STABLE_CYCLES cycles: go to S_HOLD.
- S_HOLD:
  - Outputs: locked_o=1, sys_reset_n_o=0.
  - lock_s=0: go to S_WAIT.
  - After RST_HOLD_CYCLES cycles: go to S_RUN.
- S_RUN:
  - Outputs: sys_reset_n_o=1, locked_o=1.
  - retry_cnt clears on entry.
  - lock_s=0: sys_reset_n_o=0, locked_o=0, relock_evt_o=1 for one cycle, go to S_PLLRST.
- S_FAIL:
  - Outputs: pll_reset_o=0, sys_reset_n_o=0, fail_o=1.
  - lock_i is ignored; only rst_n exits this state.
- Simultaneous events: a lock_s change on the same cycle as a phase end takes priority over the phase end in S_STABLE, S_HOLD and S_RUN. In S_WAIT, lock_s=1 beats timeout.
- Reset mid-operation: rst_n low at any time forces all outputs to their reset values immediately (asynchronously) and restarts the sequence.
- Worst case from loss of lock_i to sys_reset_n_o low is 3 cycles.

Decomposition:
- Package pll_sup_pkg holds:
  - the state enum (S_PLLRST, S_WAIT, S_STABLE, S_HOLD, S_RUN, S_FAIL);
  - default cycle constants for 27 MHz;
  - a CNT_W helper function.
- Sub-module sync_2ff: a generic 1-bit two-flop synchronizer with asynchronous active-low reset to 0, reused elsewhere.

Test Plan:
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=20, RST_HOLD_CYCLES=8, MAX_RETRIES=2. Cycle 0 is the first edge after rst_n releases.
1. Nominal: lock_i rises before edge 30 and stays high.
   - pll_reset_o high on cycles 0-3.
   - locked_o rises at cycle 53.
   - sys_reset_n_o rises at cycle 61; fail_o=0.
2. Lock never rises.
   - Three pll_reset_o pulses of 4 cycles, spaced 104 cycles apart.
   - fail_o=1 from cycle 312; retry_cnt_o=2.
   - sys_reset_n_o stays 0; a later lock_i is ignored.
3. Glitch: lock_i high for 10 cycles inside S_STABLE, then low, then high permanently.
   - Returns to S_WAIT; retry_cnt_o unchanged.
   - sys_reset_n_o stays 0 until a full 20+8 cycles after the final rise plus the sync delay.
4. Lock loss in S_RUN: lock_i falls.
   - sys_reset_n_o=0 and locked_o=0 within 3 cycles.
   - relock_evt_o is exactly one 1-cycle pulse.
   - pll_reset_o pulses for 4 cycles; relock follows the scenario-1 timing; retry_cnt_o=0.
5. Reset mid-S_HOLD: rst_n pulsed low while in S_HOLD.
   - All outputs take reset values asynchronously, before the next clkin edge.
   - The sequence restarts from S_PLLRST.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared types, default 27 MHz timing constants and helpers for the rPLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    S_PLLRST = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_HOLD   = 3'd3,
    S_RUN    = 3'd4,
    S_FAIL   = 3'd5
  } state_e;

  localparam int unsigned DEF_PLL_RST_CYCLES  = 27;
  localparam int unsigned DEF_LOCK_TIMEOUT    = 2_700_000;
  localparam int unsigned DEF_STABLE_CYCLES   = 270_000;
  localparam int unsigned DEF_RST_HOLD_CYCLES = 16;
  localparam int unsigned DEF_MAX_RETRIES     = 7;
  localparam int unsigned RETRY_W             = 4;

  typedef struct packed {
    logic pll_reset;
    logic sys_reset_n;
    logic locked;
    logic fail;
  } sup_out_t;

  localparam sup_out_t OUT_RESET = '{pll_reset: 1'b1, sys_reset_n: 1'b0, locked: 1'b0, fail: 1'b0};

  // Bits needed to count 0 .. (longest phase - 1).
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic sup_out_t decode_out(input state_e s);
    sup_out_t o;
    o.pll_reset   = (s == S_PLLRST);
    o.sys_reset_n = (s == S_RUN);
    o.locked      = (s == S_HOLD) || (s == S_RUN);
    o.fail        = (s == S_FAIL);
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer; both flops clear to 0 on asynchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      // NOTE: non-blocking so r_sync takes the old r_meta; blocking would collapse the chain to one flop.
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the Gowin rPLL reset from the crystal clock, qualifies LOCK and
// holds the core reset until the PLL has been stably locked for a while.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES  = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES   = DEF_STABLE_CYCLES,
  parameter int unsigned RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int unsigned MAX_RETRIES     = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W           = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT,
                                                     STABLE_CYCLES, RST_HOLD_CYCLES)
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       lock_i,
  output logic       pll_reset_o,
  output logic       sys_reset_n_o,
  output logic       locked_o,
  output logic       fail_o,
  output logic [3:0] retry_cnt_o,
  output logic       relock_evt_o
);

  localparam logic [CNT_W-1:0]   PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  logic               w_lock_s;
  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] w_retry_nxt;
  logic               w_relock;
  sup_out_t           r_out;
  logic               r_relock_evt;

  // LOCK comes from the PLL's own domain; only the synchronised copy drives decisions.
  sync_2ff u_lock_sync (
    .clk   (clkin),
    .rst_n (rst_n),
    .i_d   (lock_i),
    .o_q   (w_lock_s)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    w_relock    = 1'b0;
    w_cnt_nxt   = r_cnt;

    unique case (r_state)
      S_PLLRST: begin
        if (r_cnt == PLL_RST_LAST) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_lock_s) begin
          w_state_nxt = S_STABLE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          if (r_retry == RETRY_MAX) begin
            w_state_nxt = S_FAIL;
          end else begin
            w_retry_nxt = r_retry + 1'b1;
            w_state_nxt = S_PLLRST;
          end
        end
      end
      S_STABLE: begin
        if (!w_lock_s)                  w_state_nxt = S_WAIT;
        else if (r_cnt == STABLE_LAST)  w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT;
        end else if (r_cnt == HOLD_LAST) begin
          w_state_nxt = S_RUN;
          w_retry_nxt = '0;
        end
      end
      S_RUN: begin
        if (!w_lock_s) begin
          w_state_nxt = S_PLLRST;
          w_relock    = 1'b1;
        end
      end
      S_FAIL: begin
        w_state_nxt = S_FAIL;
      end
      default: begin
        w_state_nxt = S_PLLRST;
      end
    endcase

    // Phase timer restarts on every transition; RUN and FAIL have no timed phase.
    if (w_state_nxt != r_state)
      w_cnt_nxt = '0;
    else if ((r_state != S_RUN) && (r_state != S_FAIL))
      w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_PLLRST;
      r_cnt        <= '0;
      r_retry      <= '0;
      r_out        <= OUT_RESET;
      r_relock_evt <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_retry      <= w_retry_nxt;
      r_out        <= decode_out(w_state_nxt);
      r_relock_evt <= w_relock;
    end
  end

  assign pll_reset_o   = r_out.pll_reset;
  assign sys_reset_n_o = r_out.sys_reset_n;
  assign locked_o      = r_out.locked;
  assign fail_o        = r_out.fail;
  assign retry_cnt_o   = r_retry;
  assign relock_evt_o  = r_relock_evt;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: timing table, corner-case sequences and a
// randomized LOCK waveform compared against a phase-level reference model.
module tb_pll_lock_supervisor;

  localparam int unsigned P_RST  = 4;
  localparam int unsigned P_TO   = 100;
  localparam int unsigned P_ST   = 20;
  localparam int unsigned P_HOLD = 8;
  localparam int unsigned P_MAXR = 2;

  logic       clkin  = 1'b0;
  logic       rst_n  = 1'b0;
  logic       lock_i = 1'b0;
  logic       pll_reset_o;
  logic       sys_reset_n_o;
  logic       locked_o;
  logic       fail_o;
  logic [3:0] retry_cnt_o;
  logic       relock_evt_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES  (P_RST),
    .LOCK_TIMEOUT    (P_TO),
    .STABLE_CYCLES   (P_ST),
    .RST_HOLD_CYCLES (P_HOLD),
    .MAX_RETRIES     (P_MAXR)
  ) dut (
    .clkin         (clkin),
    .rst_n         (rst_n),
    .lock_i        (lock_i),
    .pll_reset_o   (pll_reset_o),
    .sys_reset_n_o (sys_reset_n_o),
    .locked_o      (locked_o),
    .fail_o        (fail_o),
    .retry_cnt_o   (retry_cnt_o),
    .relock_evt_o  (relock_evt_o)
  );

  always #5 clkin = ~clkin;

  // Reference model: which phase the supervisor is in and how many edges it has spent there.
  typedef enum {PH_RESETTING, PH_SEARCHING, PH_QUALIFYING, PH_HOLDING, PH_RUNNING, PH_GAVE_UP} phase_e;
  phase_e m_ph;
  int     m_elapsed;
  int     m_retry;
  bit     m_relock;
  bit     m_hist [2];

  function automatic void model_reset();
    m_ph      = PH_RESETTING;
    m_elapsed = 0;
    m_retry   = 0;
    m_relock  = 1'b0;
    m_hist[0] = 1'b0;
    m_hist[1] = 1'b0;
  endfunction

  function automatic void enter(input phase_e p);
    m_ph      = p;
    m_elapsed = 0;
  endfunction

  // One clkin edge; li is lock_i as present at that edge. The FSM sees lock_i from two edges earlier.
  function automatic void model_step(input bit li);
    bit seen;
    seen      = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = li;
    m_relock  = 1'b0;
    m_elapsed = m_elapsed + 1;
    case (m_ph)
      PH_RESETTING:  if (m_elapsed == int'(P_RST)) enter(PH_SEARCHING);
      PH_SEARCHING: begin
        if (seen) enter(PH_QUALIFYING);
        else if (m_elapsed == int'(P_TO)) begin
          if (m_retry == int'(P_MAXR)) enter(PH_GAVE_UP);
          else begin
            m_retry = m_retry + 1;
            enter(PH_RESETTING);
          end
        end
      end
      PH_QUALIFYING: begin
        if (!seen) enter(PH_SEARCHING);
        else if (m_elapsed == int'(P_ST)) enter(PH_HOLDING);
      end
      PH_HOLDING: begin
        if (!seen) enter(PH_SEARCHING);
        else if (m_elapsed == int'(P_HOLD)) begin
          m_retry = 0;
          enter(PH_RUNNING);
        end
      end
      PH_RUNNING: begin
        if (!seen) begin
          m_relock = 1'b1;
          enter(PH_RESETTING);
        end
      end
      default: ;
    endcase
  endfunction

  // Output vector layout: {pll_reset, sys_reset_n, locked, fail, relock_evt, retry[3:0]}
  function automatic logic [8:0] model_vec();
    return {m_ph == PH_RESETTING, m_ph == PH_RUNNING,
            (m_ph == PH_HOLDING) || (m_ph == PH_RUNNING),
            m_ph == PH_GAVE_UP, m_relock, 4'(m_retry)};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {pll_reset_o, sys_reset_n_o, locked_o, fail_o, relock_evt_o, retry_cnt_o};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic tick();
    bit li;
    li = lock_i;
    @(posedge clkin);
    if (!rst_n) model_reset();
    else        model_step(li);
    @(negedge clkin);
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    @(negedge clkin);
    rst_n = 1'b0;
    model_reset();
    @(negedge clkin);
    check("reset_values", 32'(dut_vec()), 32'(9'b1_0000_0000));
    @(negedge clkin);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  typedef struct {
    int         cyc;
    logic       lock_nxt;
    logic       pr;
    logic       srn;
    logic       lk;
    logic       fl;
    logic       rev;
    logic [3:0] rc;
  } vec_t;

  function automatic vec_t mk(input int c, input logic ln, input logic pr, input logic srn,
                              input logic lk, input logic fl, input logic rev, input logic [3:0] rc);
    vec_t v;
    v.cyc = c; v.lock_nxt = ln; v.pr = pr; v.srn = srn;
    v.lk = lk; v.fl = fl; v.rev = rev; v.rc = rc;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [$];
    int         bad;
    int         hold_left;
    logic       exp_pr;
    logic [8:0] exp_v;

    // Nominal lock-up, then lock loss in RUN and relock with the same timing.
    tbl.push_back(mk(  0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(  3, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(  4, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 30, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 52, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 53, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk( 60, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk( 61, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk( 80, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk( 82, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk( 83, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk( 84, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 86, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 87, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(113, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(135, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(136, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(143, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(144, 1, 0, 1, 1, 0, 0, 0));

    lock_i = 1'b0;
    do_reset();
    foreach (tbl[i]) begin
      run_to(tbl[i].cyc);
      exp_v = {tbl[i].pr, tbl[i].srn, tbl[i].lk, tbl[i].fl, tbl[i].rev, tbl[i].rc};
      check($sformatf("table_c%0d", tbl[i].cyc), 32'(dut_vec()), 32'(exp_v));
      lock_i = tbl[i].lock_nxt;
    end

    // Lock never arrives: three reset pulses 104 cycles apart, then sticky fail.
    lock_i = 1'b0;
    do_reset();
    bad = 0;
    for (int c = 0; c <= 320; c++) begin
      exp_pr = (c < 312) && ((c % 104) < 4);
      if (pll_reset_o !== exp_pr) bad++;
      if (sys_reset_n_o !== 1'b0) bad++;
      if (c == 311) check("noloc_fail_before", 32'(fail_o), 32'd0);
      if (c == 312) begin
        check("noloc_fail_at_312", 32'(fail_o), 32'd1);
        check("noloc_retry", 32'(retry_cnt_o), 32'd2);
      end
      if (c < 320) tick();
    end
    check("noloc_pulse_pattern", 32'(bad), 32'd0);
    lock_i = 1'b1;
    repeat (60) tick();
    check("fail_ignores_lock", 32'(dut_vec()), 32'(9'b0_0010_0010));

    // Glitch inside STABLE after one timeout: back to WAIT, retry count kept.
    lock_i = 1'b0;
    do_reset();
    run_to(104);
    check("glitch_retry_after_timeout", 32'(retry_cnt_o), 32'd1);
    check("glitch_second_pll_reset", 32'(pll_reset_o), 32'd1);
    run_to(110); lock_i = 1'b1;
    run_to(120); lock_i = 1'b0;
    run_to(123);
    check("glitch_back_to_wait", 32'(dut_vec()), 32'(9'b0_0000_0001));
    run_to(125); lock_i = 1'b1;
    run_to(147);
    check("glitch_locked_not_early", 32'(locked_o), 32'd0);
    run_to(148);
    check("glitch_locked_rise", 32'(dut_vec()), 32'(9'b0_0100_0001));
    run_to(155);
    check("glitch_sysrst_not_early", 32'(sys_reset_n_o), 32'd0);
    run_to(156);
    check("glitch_run_entry", 32'(dut_vec()), 32'(9'b0_1100_0000));

    // Asynchronous reset while in HOLD, then a clean restart.
    lock_i = 1'b0;
    do_reset();
    lock_i = 1'b1;
    run_to(28);
    check("arst_in_hold", 32'(dut_vec()), 32'(9'b0_0100_0000));
    #2 rst_n = 1'b0;
    #1 check("arst_async_values", 32'(dut_vec()), 32'(9'b1_0000_0000));
    model_reset();
    @(negedge clkin);
    rst_n = 1'b1;
    cyc   = 0;
    check("arst_restart_c0", 32'(pll_reset_o), 32'd1);
    run_to(3);
    check("arst_restart_c3", 32'(pll_reset_o), 32'd1);
    run_to(4);
    check("arst_restart_c4", 32'(pll_reset_o), 32'd0);
    run_to(24);
    check("arst_locked_c24", 32'(locked_o), 32'd0);
    run_to(25);
    check("arst_locked_c25", 32'(locked_o), 32'd1);
    run_to(33);
    check("arst_run_c33", 32'(sys_reset_n_o), 32'd1);

    // Random LOCK waveforms compared cycle by cycle against the model.
    for (int run = 0; run < 4; run++) begin
      lock_i = 1'b0;
      do_reset();
      hold_left = 0;
      for (int c = 0; c < 900; c++) begin
        check($sformatf("random_run%0d", run), 32'(dut_vec()), 32'(model_vec()));
        if (hold_left == 0) begin
          lock_i = ~lock_i;
          case ($urandom_range(3, 0))
            0:       hold_left = $urandom_range(12, 1);
            1:       hold_left = $urandom_range(40, 15);
            2:       hold_left = $urandom_range(200, 50);
            default: hold_left = lock_i ? $urandom_range(500, 300) : $urandom_range(400, 250);
          endcase
        end
        hold_left--;
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
